// File: rtl/instr_enc_pkg.sv
// -----------------------------------------------------------------------------
// instr_enc_pkg
// Shared MIPS encoding table for the instruction loader and the single-cycle
// control decoder: symbolic mnemonics, primary opcodes, R-type funct codes,
// loader FSM states and small helpers that pack R-/I-type words.
// -----------------------------------------------------------------------------
package instr_enc_pkg;

  // Symbolic mnemonics carried on the loader's 4-bit in_op field.
  // Codes 10..15 are unused and flagged as invalid by the encoder.
  typedef enum logic [3:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_ADDI = 4'd5,
    MN_LW   = 4'd6,
    MN_SW   = 4'd7,
    MN_BEQ  = 4'd8,
    MN_NOP  = 4'd9
  } mnemonic_t;

  // Primary opcodes (instruction bits [31:26]); names match the decoder side.
  localparam logic [5:0] _RType = 6'h00;
  localparam logic [5:0] _addi  = 6'h08;
  localparam logic [5:0] _lw    = 6'h23;
  localparam logic [5:0] _sw    = 6'h2B;
  localparam logic [5:0] _beq   = 6'h04;

  // R-type funct codes (instruction bits [5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Loader session states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  // {opcode, rs, rt, rd, shamt, funct} with shamt fixed at zero.
  function automatic logic [31:0] r_type(input logic [4:0] rs,
                                         input logic [4:0] rt,
                                         input logic [4:0] rd,
                                         input logic [5:0] funct);
    return {_RType, rs, rt, rd, 5'b0, funct};
  endfunction

  // {opcode, rs, rt, imm}; the immediate is passed through untouched.
  function automatic logic [31:0] i_type(input logic [5:0]  opcode,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [15:0] imm);
    return {opcode, rs, rt, imm};
  endfunction

endpackage : instr_enc_pkg

// File: rtl/instr_field_encoder.sv
// -----------------------------------------------------------------------------
// instr_field_encoder
// Purely combinational: turns one symbolic instruction beat into a 32-bit
// MIPS word.
//   op        in  4   mnemonic (see mnemonic_t)
//   rs,rt,rd  in  5   register fields (rd ignored by I-type)
//   imm       in  16  immediate / branch offset, raw
//   word      out 32  encoded instruction (0 for NOP and invalid codes)
//   valid_op  out 1   op is one of the ten defined mnemonics
// -----------------------------------------------------------------------------
module instr_field_encoder
  import instr_enc_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        valid_op
);

  always_comb begin
    // NOTE: both outputs get a default before the case so every path assigns
    // them; a missing assignment in a combinational block infers a latch.
    word     = 32'h0000_0000;
    valid_op = 1'b1;
    case (op)
      MN_ADD:  word = r_type(rs, rt, rd, FUNCT_ADD);
      MN_SUB:  word = r_type(rs, rt, rd, FUNCT_SUB);
      MN_AND:  word = r_type(rs, rt, rd, FUNCT_AND);
      MN_OR:   word = r_type(rs, rt, rd, FUNCT_OR);
      MN_SLT:  word = r_type(rs, rt, rd, FUNCT_SLT);
      MN_ADDI: word = i_type(_addi, rs, rt, imm);
      MN_LW:   word = i_type(_lw, rs, rt, imm);
      MN_SW:   word = i_type(_sw, rs, rt, imm);
      MN_BEQ:  word = i_type(_beq, rs, rt, imm);
      MN_NOP:  word = 32'h0000_0000;
      default: valid_op = 1'b0;
    endcase
  end

endmodule : instr_field_encoder

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts symbolic instruction beats over valid/ready, encodes them and
// writes the words to consecutive instruction-memory addresses, holding the
// CPU in reset until prog_len valid instructions have been written.
//   clk, rst       rising-edge clock; synchronous active-low reset
//   start          pulse: begin a session, samples prog_len (ignored in LOAD)
//   prog_len       valid instructions to write, 0..2**ADDR_W
//   in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_imm   beat interface
//   im_we, im_addr, im_wdata   instruction-memory write port (registered)
//   busy           LOAD state or a write still on the port
//   done           session complete
//   bad_op         sticky: an invalid mnemonic was accepted this session
//   cpu_rst        active-low CPU reset, released only in DONE
// -----------------------------------------------------------------------------
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
  output logic              bad_op,
  output logic              cpu_rst
);

  load_state_t       state;
  logic [ADDR_W:0]   len_q;      // prog_len latched at start
  logic [ADDR_W:0]   acc_cnt;    // valid-mnemonic beats accepted
  logic [ADDR_W:0]   wr_cnt;     // writes already retired from the port
  logic [ADDR_W-1:0] next_addr;  // address for the next write, wraps

  logic [31:0] enc_word;
  logic        enc_valid;
  logic        accept;
  logic        write_accept;
  logic        last_write;

  instr_field_encoder u_enc (
    .op       (in_op),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .imm      (in_imm),
    .word     (enc_word),
    .valid_op (enc_valid)
  );

  // Ready depends on registered state only, never on in_valid.
  assign in_ready     = (state == ST_LOAD) && (acc_cnt < len_q);
  assign accept       = in_valid && in_ready;
  assign write_accept = accept && enc_valid;
  assign busy         = (state == ST_LOAD) || im_we;

  // The write currently on the port is the final one of the session; the
  // state moves to DONE at the edge that retires it.
  assign last_write = im_we && ((wr_cnt + (ADDR_W+1)'(1)) == len_q);

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking = would leak new values into later lines.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      acc_cnt   <= '0;
      wr_cnt    <= '0;
      next_addr <= '0;
      im_we     <= 1'b0;
      im_addr   <= '0;
      im_wdata  <= '0;
      done      <= 1'b0;
      bad_op    <= 1'b0;
      cpu_rst   <= 1'b0;
    end else begin
      im_we <= 1'b0;  // one-cycle write strobe
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            len_q     <= prog_len;
            acc_cnt   <= '0;
            wr_cnt    <= '0;
            next_addr <= '0;
            bad_op    <= 1'b0;
            if (prog_len == '0) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b1;
            end else begin
              state   <= ST_LOAD;
              done    <= 1'b0;
              cpu_rst <= 1'b0;
            end
          end
        end

        ST_LOAD: begin
          if (write_accept) begin
            im_we     <= 1'b1;
            im_addr   <= next_addr;
            im_wdata  <= enc_word;
            next_addr <= next_addr + ADDR_W'(1);
            acc_cnt   <= acc_cnt + (ADDR_W+1)'(1);
          end
          // Invalid beats are consumed without a write or address advance.
          if (accept && !enc_valid) begin
            bad_op <= 1'b1;
          end
          if (im_we) begin
            wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
          end
          if (last_write) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            cpu_rst <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : instr_encoder_loader

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed sessions from the test plan followed by randomized sessions. A
// session-level reference model (expected write list with arrival cycle,
// ready expectation, sticky bad_op) is compared against what the DUT does.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   prog_len;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs, in_rt, in_rd;
  logic [15:0]       in_imm;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              busy, done, bad_op, cpu_rst;

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .prog_len (prog_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_rd    (in_rd),
    .in_imm   (in_imm),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .busy     (busy),
    .done     (done),
    .bad_op   (bad_op),
    .cpu_rst  (cpu_rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
  } beat_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  beat_t beat_q[$];   // directed beats offered first, in order
  wr_t   exp_q[$];    // writes the model expects
  wr_t   obs_q[$];    // writes seen on the port
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference encoder written from the opcode/funct tables.
  function automatic logic [31:0] ref_enc(input beat_t b);
    logic [31:0] funct_tab [5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    logic [31:0] opc_tab   [4] = '{32'h08, 32'h23, 32'h2B, 32'h04};
    logic [31:0] rs  = 32'(b.rs);
    logic [31:0] rt  = 32'(b.rt);
    logic [31:0] rd  = 32'(b.rd);
    logic [31:0] imm = 32'(b.imm);
    int op = int'(b.op);
    if (op < 5) return (rs << 21) | (rt << 16) | (rd << 11) | funct_tab[op];
    if (op < 9) return (opc_tab[op - 5] << 26) | (rs << 21) | (rt << 16) | imm;
    return 32'h0;  // NOP (invalid codes never produce a write)
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.op  = 4'($urandom_range(0, 15));
    b.rs  = 5'($urandom);
    b.rt  = 5'($urandom);
    b.rd  = 5'($urandom);
    b.imm = 16'($urandom);
    return b;
  endfunction

  function automatic beat_t mk(input int op, input int rs, input int rt, input int rd, input int imm);
    beat_t b;
    b.op = 4'(op); b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.imm = 16'(imm);
    return b;
  endfunction

  // Advance one clock; sample on the falling edge and log any write.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (im_we === 1'b1) obs_q.push_back('{cyc, im_addr, im_wdata});
  endtask

  // One load session: start with len, offer beat_q then random beats with
  // gap_pct% idle cycles, until done or the cycle budget runs out.
  task automatic session(input int len, input int gap_pct, input string name);
    int                nacc = 0;
    logic [ADDR_W-1:0] addr_m = '0;
    logic              bad_m = 1'b0;
    int                start_cyc;
    int                done_cyc = -1;
    int                exp_done;
    beat_t             b;
    exp_q.delete();
    obs_q.delete();
    prog_len  = (ADDR_W+1)'(len);
    start     = 1'b1;
    in_valid  = 1'b0;
    start_cyc = cyc;
    step();
    start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      check({name, "/cpu_rst_held"}, 32'(cpu_rst), 32'd0);
      check({name, "/busy"}, 32'(busy), 32'd1);
      check({name, "/in_ready"}, 32'(in_ready), 32'(nacc < len));
      check({name, "/bad_op"}, 32'(bad_op), 32'(bad_m));
      b        = (beat_q.size() > 0) ? beat_q[0] : rand_beat();
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_op    = b.op;
      in_rs    = b.rs;
      in_rt    = b.rt;
      in_rd    = b.rd;
      in_imm   = b.imm;
      if (in_valid && nacc < len) begin
        if (beat_q.size() > 0) void'(beat_q.pop_front());
        if (b.op <= 4'd9) begin
          exp_q.push_back('{cyc + 1, addr_m, ref_enc(b)});
          addr_m = addr_m + 1'b1;
          nacc++;
        end else begin
          bad_m = 1'b1;
        end
      end
      step();
    end
    in_valid = 1'b0;
    beat_q.delete();

    check({name, "/done_reached"}, 32'(done), 32'd1);
    exp_done = (exp_q.size() == 0) ? start_cyc + 1 : exp_q[exp_q.size() - 1].cyc + 1;
    check({name, "/done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, "/cpu_rst_released"}, 32'(cpu_rst), 32'd1);
    check({name, "/ready_in_done"}, 32'(in_ready), 32'd0);
    check({name, "/busy_in_done"}, 32'(busy), 32'd0);
    check({name, "/we_in_done"}, 32'(im_we), 32'd0);
    check({name, "/bad_op_final"}, 32'(bad_op), 32'(bad_m));
    check({name, "/write_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s/w%0d_cycle", name, i), 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
      check($sformatf("%s/w%0d_addr", name, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s/w%0d_data", name, i), obs_q[i].data, exp_q[i].data);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; prog_len = '0; in_valid = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;

    // Reset state.
    step(); step();
    check("rst/im_we", 32'(im_we), 32'd0);
    check("rst/im_addr", 32'(im_addr), 32'd0);
    check("rst/im_wdata", im_wdata, 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd0);
    check("rst/done", 32'(done), 32'd0);
    check("rst/bad_op", 32'(bad_op), 32'd0);
    check("rst/cpu_rst", 32'(cpu_rst), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    // Single ADD.
    beat_q.push_back(mk(0, 1, 2, 3, 0));
    session(1, 0, "add1");
    check("add1/word_const", obs_q.size() > 0 ? obs_q[0].data : 32'hDEAD_BEEF, 32'h0022_1820);

    // Four I-type beats back to back.
    beat_q.push_back(mk(5, 0, 1, 7, 5));
    beat_q.push_back(mk(6, 2, 5, 0, 4));
    beat_q.push_back(mk(7, 0, 4, 0, 8));
    beat_q.push_back(mk(8, 1, 2, 0, 16'hFFFF));
    session(4, 0, "itype4");
    check("itype4/beq_const", obs_q.size() > 3 ? obs_q[3].data : 32'h0, 32'h1022_FFFF);

    // Invalid mnemonic, then NOP and ADD.
    beat_q.push_back(mk(12, 3, 3, 3, 3));
    beat_q.push_back(mk(9, 7, 7, 7, 7));
    beat_q.push_back(mk(0, 1, 2, 3, 0));
    session(2, 0, "badop");

    // Gappy valid stream with beats still offered after the count is reached.
    for (int i = 0; i < 2; i++) beat_q.push_back(mk($urandom_range(0, 9), 4, 5, 6, 9));
    session(2, 50, "gaps");

    // Reset in the middle of a 4-instruction load.
    obs_q.delete();
    prog_len = (ADDR_W+1)'(4);
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_op = 4'd1; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd5; in_imm = '0;
    for (int k = 0; k < 20 && obs_q.size() < 2; k++) step();
    check("midrst/two_writes", 32'(obs_q.size()), 32'd2);
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    check("midrst/im_we", 32'(im_we), 32'd0);
    check("midrst/done", 32'(done), 32'd0);
    check("midrst/cpu_rst", 32'(cpu_rst), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    check("midrst/in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    check("midrst/idle_ready", 32'(in_ready), 32'd0);
    session(3, 20, "after_rst");

    // Empty program from IDLE, then reload from DONE.
    rst = 1'b0; step(); rst = 1'b1; step();
    session(0, 0, "len0");
    session(1, 0, "reload1");
    session(0, 0, "done_len0");

    // Randomized sessions, including an exact full-memory fill.
    for (int s = 0; s < 6; s++)
      session($urandom_range(1, 24), $urandom_range(0, 60), $sformatf("rand%0d", s));
    session(DEPTH, 10, "full");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instr_encoder_loader
